// File: rtl/frame_stream_gen.sv
// Command-driven frame generator: decodes SET_PIX/START/STOP words from a FWFT FIFO and
// streams header + N_PAY payload words per frame into a PC-bound FIFO, honouring backpressure.
module frame_stream_gen #(
  parameter int unsigned N_PAY = 8,
  parameter int unsigned CNT_W = 22
) (
  input  logic             bus_clk,
  input  logic             reset,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_empty,
  output logic             cmd_ack,
  output logic [31:0]      out_data,
  output logic             out_wr,
  input  logic             out_full,
  output logic             busy,
  output logic [CNT_W-1:0] frames_left,
  output logic             err_cmd
);

  localparam int unsigned KW = (N_PAY > 1) ? $clog2(N_PAY) : 1;
  localparam logic [KW-1:0] KLast = KW'(N_PAY - 1);
  localparam logic [3:0] OpSetPix = 4'h1;
  localparam logic [3:0] OpStart  = 4'h2;
  localparam logic [3:0] OpStop   = 4'h3;

  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

  state_e           state_q, state_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             out_wr_q, out_wr_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic [CNT_W-1:0] frame_idx_q, frame_idx_d;
  logic             stop_pend_q, stop_pend_d;
  logic             err_cmd_q, err_cmd_d;
  logic [11:0]      top_pix_q, top_pix_d;
  logic [11:0]      bot_pix_q, bot_pix_d;
  logic [KW-1:0]    k_q, k_d;

  logic [3:0] opcode;
  logic       can_pop;
  logic       stop_pop;
  logic       unused_cmd_bits;

  assign opcode          = cmd_data[31:28];
  // cmd_ack high means the FIFO head is being popped this cycle and is stale.
  assign can_pop         = !cmd_empty && !cmd_ack_q;
  assign unused_cmd_bits = ^cmd_data[27:24];

  always_comb begin
    state_d       = state_q;
    cmd_ack_d     = 1'b0;
    out_wr_d      = 1'b0;
    out_data_d    = out_data_q;
    frames_left_d = frames_left_q;
    frame_idx_d   = frame_idx_q;
    stop_pend_d   = stop_pend_q;
    err_cmd_d     = err_cmd_q;
    top_pix_d     = top_pix_q;
    bot_pix_d     = bot_pix_q;
    k_d           = k_q;
    stop_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (can_pop) begin
          cmd_ack_d = 1'b1;
          case (opcode)
            OpSetPix: begin
              top_pix_d = cmd_data[23:12];
              bot_pix_d = cmd_data[11:0];
            end
            OpStart: begin
              frames_left_d = cmd_data[CNT_W-1:0];
              frame_idx_d   = '0;
              if (cmd_data[CNT_W-1:0] != '0) state_d = StHdr;
            end
            OpStop: ;
            default: err_cmd_d = 1'b1;
          endcase
        end
      end
      StHdr, StPay: begin
        // Only STOP may be consumed mid-frame; everything else waits for IDLE.
        stop_pop = can_pop && (opcode == OpStop);
        if (stop_pop) begin
          cmd_ack_d   = 1'b1;
          stop_pend_d = 1'b1;
        end
        if (!out_full) begin
          out_wr_d = 1'b1;
          if (state_q == StHdr) begin
            out_data_d = {8'hA5, 24'(frame_idx_q)};
            k_d        = '0;
            state_d    = StPay;
          end else begin
            out_data_d = {4'h0, top_pix_q + 12'(k_q), 4'h0, bot_pix_q};
            k_d        = k_q + KW'(1);
            if (k_q == KLast) begin
              frames_left_d = frames_left_q - CNT_W'(1);
              frame_idx_d   = frame_idx_q + CNT_W'(1);
              if (frames_left_q == CNT_W'(1) || stop_pend_q || stop_pop) begin
                state_d       = StIdle;
                frames_left_d = '0;
                stop_pend_d   = 1'b0;
              end else begin
                state_d = StHdr;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_ack_q     <= 1'b0;
      out_wr_q      <= 1'b0;
      out_data_q    <= '0;
      frames_left_q <= '0;
      frame_idx_q   <= '0;
      stop_pend_q   <= 1'b0;
      err_cmd_q     <= 1'b0;
      top_pix_q     <= 12'h015;
      bot_pix_q     <= 12'h540;
      k_q           <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ack_q     <= cmd_ack_d;
      out_wr_q      <= out_wr_d;
      out_data_q    <= out_data_d;
      frames_left_q <= frames_left_d;
      frame_idx_q   <= frame_idx_d;
      stop_pend_q   <= stop_pend_d;
      err_cmd_q     <= err_cmd_d;
      top_pix_q     <= top_pix_d;
      bot_pix_q     <= bot_pix_d;
      k_q           <= k_d;
    end
  end

  assign cmd_ack     = cmd_ack_q;
  assign out_wr      = out_wr_q;
  assign out_data    = out_data_q;
  assign frames_left = frames_left_q;
  assign err_cmd     = err_cmd_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed-sequence bench for frame_stream_gen: a queue models the FWFT command FIFO and the
// expected output stream is built from the frame format rules.
module tb_frame_stream_gen;

  localparam int unsigned N_PAY = 8;
  localparam int unsigned CNT_W = 22;

  logic             bus_clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      cmd_data = 32'h0;
  logic             cmd_empty = 1'b1;
  logic             cmd_ack;
  logic [31:0]      out_data;
  logic             out_wr;
  logic             out_full = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] frames_left;
  logic             err_cmd;

  frame_stream_gen #(.N_PAY(N_PAY), .CNT_W(CNT_W)) dut (
    .bus_clk     (bus_clk),
    .reset       (reset),
    .cmd_data    (cmd_data),
    .cmd_empty   (cmd_empty),
    .cmd_ack     (cmd_ack),
    .out_data    (out_data),
    .out_wr      (out_wr),
    .out_full    (out_full),
    .busy        (busy),
    .frames_left (frames_left),
    .err_cmd     (err_cmd)
  );

  always #5 bus_clk = ~bus_clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cmd_q[$];
  logic [31:0] cap[$];
  logic [31:0] exp_q[$];
  bit          rand_full = 1'b0;
  logic        prev_full = 1'b0;
  logic        ack_seen = 1'b0;
  logic        wr_seen = 1'b0;
  int          ack_count = 0;
  logic [11:0] rt, rb;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, obs, expv);
    end
  endtask

  task automatic sync_fifo();
    cmd_empty = (cmd_q.size() == 0);
    cmd_data  = cmd_empty ? 32'h0 : cmd_q[0];
  endtask

  task automatic push(input logic [31:0] w);
    cmd_q.push_back(w);
    sync_fifo();
  endtask

  // One bus_clk cycle: sample registered outputs before the edge, then update inputs after it.
  task automatic tick();
    ack_seen = cmd_ack;
    wr_seen  = out_wr;
    if (out_wr) begin
      cap.push_back(out_data);
      check("wr_while_full", 32'(prev_full), 32'd0);
    end
    if (cmd_ack) ack_count++;
    prev_full = out_full;
    @(posedge bus_clk);
    #1;
    if (ack_seen && cmd_q.size() > 0) void'(cmd_q.pop_front());
    out_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    sync_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_frames(input int n, input logic [11:0] top, input logic [11:0] bot);
    for (int f = 0; f < n; f++) begin
      exp_q.push_back({8'hA5, 24'(f)});
      for (int k = 0; k < int'(N_PAY); k++) exp_q.push_back({4'h0, top + 12'(k), 4'h0, bot});
    end
  endtask

  task automatic compare_words(input string tag);
    int n;
    check({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), cap[i], exp_q[i]);
    cap.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] op_start(input int n);
    return {4'h2, 28'(n)};
  endfunction

  function automatic logic [31:0] op_setpix(input logic [11:0] t, input logic [11:0] b);
    return {4'h1, 4'h0, t, b};
  endfunction

  initial begin
    sync_fifo();
    repeat (2) @(posedge bus_clk);
    #1;
    check("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    check("rst_out_wr", 32'(out_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_cmd), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_frames_left", 32'(frames_left), 32'd0);
    reset = 1'b0;

    // START(2) with default pixels, including header latency after the pop.
    push(op_start(2));
    for (int i = 0; i < 10 && !ack_seen; i++) tick();
    check("start_acked", 32'(ack_seen), 32'd1);
    tick();
    check("hdr_latency", 32'(wr_seen), 32'd1);
    run(40);
    expect_frames(2, 12'h015, 12'h540);
    compare_words("start2");
    check("start2_busy", 32'(busy), 32'd0);
    check("start2_frames_left", 32'(frames_left), 32'd0);

    // Pixel wrap at 4096.
    push(op_setpix(12'hFFE, 12'h123));
    push(op_start(1));
    run(30);
    expect_frames(1, 12'hFFE, 12'h123);
    compare_words("wrap");

    // Random backpressure.
    rand_full = 1'b1;
    push(op_start(3));
    run(300);
    rand_full = 1'b0;
    out_full  = 1'b0;
    run(3);
    expect_frames(3, 12'hFFE, 12'h123);
    compare_words("bp3");

    // STOP during frame 0 of START(100); SET_PIX behind it must wait for IDLE.
    rt = 12'($urandom_range(0, 4095));
    rb = 12'($urandom_range(0, 4095));
    push(op_start(100));
    for (int i = 0; i < 20 && cap.size() == 0; i++) tick();
    check("stop_hdr_seen", 32'(cap.size()), 32'd1);
    push(32'h3000_0000);
    push(op_setpix(rt, rb));
    run(4);
    check("stop_midframe_busy", 32'(busy), 32'd1);
    check("setpix_held", 32'(cmd_q.size()), 32'd1);
    run(40);
    expect_frames(1, 12'hFFE, 12'h123);
    compare_words("stop");
    check("stop_frames_left", 32'(frames_left), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_fifo_drained", 32'(cmd_q.size()), 32'd0);
    push(op_start(1));
    run(30);
    expect_frames(1, rt, rb);
    compare_words("newpix");

    // Illegal opcode then START(0).
    ack_count = 0;
    push(32'h7000_0000);
    push(op_start(0));
    run(12);
    check("illegal_acks", 32'(ack_count), 32'd2);
    check("illegal_no_wr", 32'(cap.size()), 32'd0);
    check("illegal_err", 32'(err_cmd), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    push(op_start(1));
    run(30);
    expect_frames(1, rt, rb);
    compare_words("after_err");
    check("err_sticky", 32'(err_cmd), 32'd1);

    // Reset in the middle of the payload.
    push(op_start(1));
    for (int i = 0; i < 30 && cap.size() < 4; i++) tick();
    check("pre_rst_words", 32'(cap.size()), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_wr", 32'(out_wr), 32'd0);
    check("async_out_data", out_data, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_frames_left", 32'(frames_left), 32'd0);
    check("async_cmd_ack", 32'(cmd_ack), 32'd0);
    check("async_err", 32'(err_cmd), 32'd0);
    @(posedge bus_clk);
    #2;
    reset = 1'b0;
    cap.delete();
    prev_full = 1'b0;
    run(10);
    check("post_rst_no_wr", 32'(cap.size()), 32'd0);
    push(op_start(1));
    run(30);
    expect_frames(1, 12'h015, 12'h540);
    compare_words("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_stream_gen.md
FRAME_STREAM_GEN -- requirements
Module: frame_stream_gen

Interface
REQ-001 Parameter N_PAY, default 8: payload words per frame, legal range 1..4096.
REQ-002 Parameter CNT_W, default 22: width of the frame count and frame index.
REQ-003 bus_clk  in  1  clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cmd_data  in  32  head word of the first-word-fall-through command FIFO; valid whenever cmd_empty=0.
REQ-006 cmd_empty  in  1  command FIFO is empty.
REQ-007 cmd_ack  out  1  registered single-cycle pop (drives FIFO rd_en).
REQ-008 out_data  out  32  registered word to the PC-bound FIFO.
REQ-009 out_wr  out  1  registered write strobe for out_data.
REQ-010 out_full  in  1  PC-bound FIFO is full.
REQ-011 busy  out  1  high in HDR and PAY states.
REQ-012 frames_left  out  CNT_W  frames still to emit, including the current frame.
REQ-013 err_cmd  out  1  sticky; set by an illegal opcode.

Function
REQ-014 Opcode field is cmd_data[31:28].
  - 0x1 SET_PIX: top_pix<=cmd_data[23:12], bot_pix<=cmd_data[11:0].
  - 0x2 START: frames_left<=cmd_data[CNT_W-1:0], frame index<=0.
  - 0x3 STOP.
  - Any other opcode: err_cmd<=1, word consumed, no other effect.
REQ-015 FSM states are IDLE, HDR, PAY; the reset state is IDLE.
REQ-016 Pop: cmd_ack pulses for exactly one cycle per consumed word; a pop occurs only when cmd_empty=0 and cmd_ack=0 in the same cycle, so a pop is never issued on two consecutive cycles.
REQ-017 IDLE pops and decodes every opcode.
  - START with count!=0 -> HDR.
  - START with count 0 -> remain in IDLE.
  - STOP in IDLE -> no-op.
REQ-018 HDR/PAY pop only when the head opcode is STOP; STOP sets stop_pend. Any other head word stays in the FIFO, unpopped, until IDLE.
REQ-019 Write rule: out_wr=1 only in a cycle where out_full=0 was sampled.
  - While out_full=1 the FSM, payload counter and data hold.
  - No word is skipped or duplicated.
REQ-020 HDR writes {8'hA5, (24-CNT_W)'b0, frame_idx}, then -> PAY with k=0.
REQ-021 PAY word k is {4'h0, (top_pix+k) mod 4096, 4'h0, bot_pix}, for k=0..N_PAY-1.
REQ-022 On the write of word k=N_PAY-1:
  - frames_left decrements and frame_idx increments (frame_idx wraps mod 2^CNT_W).
  - If the new frames_left=0 or stop_pend=1 -> IDLE; frames_left<=0 and stop_pend<=0.
  - Otherwise -> HDR.
REQ-023 A STOP popped in the same cycle as the last payload write of the final frame still ends in IDLE with stop_pend=0.
REQ-024 SET_PIX is never applied mid-frame (per REQ-018); changed pixel values appear from the next START.
REQ-025 Latency: START popped at cycle T -> header out_wr at T+1 when out_full=0. Sustained rate is 1 word/cycle, giving N_PAY+1 words per frame.
REQ-026 Total output per START(n) with no STOP is exactly n*(N_PAY+1) words.

Reset
REQ-027 On reset assertion, outputs go to their reset values immediately (asynchronously):
  - FSM -> IDLE.
  - cmd_ack, out_wr, busy, err_cmd = 0; out_data = 0; frames_left = 0.
  - frame_idx = 0; stop_pend = 0.
  - top_pix = 12'h015; bot_pix = 12'h540.
REQ-028 Reset mid-frame aborts the frame; no further out_wr occurs until a new START after reset release.

Verification
REQ-029 Reset, then START(2) with N_PAY=8 -> 18 words:
  - A5000000, 00150540..001C0540,
  - A5000001, 00150540..001C0540.
  - Then busy=0 and frames_left=0.
REQ-030 SET_PIX(top=0xFFE, bot=0x123), then START(1) -> payload FFE0123, FFF0123, 0000123 (wrap), ... through 0005123.
REQ-031 START(3) with out_full toggled pseudo-randomly -> exactly 27 words in order; no out_wr while out_full=1.
REQ-032 START(100), then STOP pushed during frame 0 -> frames 0 only (9 words) then IDLE; a SET_PIX queued behind it is applied only after IDLE.
REQ-033 Opcode 0x7, then START(0) -> err_cmd=1 stays set, two acks, no out_wr; a later START(1) still works.
REQ-034 Reset asserted at payload word 3 -> outputs zero within the same cycle; after release, START(1) emits header A5000000.
